maxnet_feeder: RTL and testbench

Front-end controller driving the Maxnet core from a word stream and returning its result on a second stream. Accepts four IEEE-754 single-precision words over a valid/ready input, presents them as x1..x4, pulses start, waits for done with a bounded timeout, and returns res with an error flag on a valid/ready output. Sits between the system-side data source/sink and the Maxnet instance. It replaces the ad-hoc stimulus sequencing used in simulation today.

---
 rtl/maxnet_pkg.sv | 19 +
 rtl/maxnet_operand_buf.sv | 44 ++++
 rtl/maxnet_feeder.sv | 127 ++++++++++++
 tb/tb_maxnet_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet front-end: word width, FSM encoding and
// single-precision constants used by stimulus code.
package maxnet_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  localparam logic [31:0] FP_0P2 = 32'h3E4CCCCD;
  localparam logic [31:0] FP_0P4 = 32'h3ECCCCCD;
  localparam logic [31:0] FP_0P6 = 32'h3F19999A;
  localparam logic [31:0] FP_0P8 = 32'h3F4CCCCD;

endpackage

// File: rtl/maxnet_operand_buf.sv
// Four-slot operand register file, written in order x1..x4 through an
// auto-incrementing write index.
module maxnet_operand_buf #(
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic               i_clear,
  input  logic [DW-1:0]      i_wdata,
  output logic [3:0][DW-1:0] o_slot,
  output logic               o_last
);

  logic [1:0]    r_idx;
  logic [DW-1:0] r_slot [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_we) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Slots are only written on a handshake, so operands hold while the core runs.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slot[gi] <= '0;
        end else if (i_we && (r_idx == 2'(gi))) begin
          r_slot[gi] <= i_wdata;
        end
      end
      assign o_slot[gi] = r_slot[gi];
    end
  endgenerate

  assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/maxnet_feeder.sv
// Streams four operands into the Maxnet core, pulses start, waits for done
// with a bounded timeout and returns the result on a valid/ready output.
module maxnet_feeder #(
  parameter int DW      = maxnet_pkg::DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mx_start,
  output logic [DW-1:0] mx_x1,
  output logic [DW-1:0] mx_x2,
  output logic [DW-1:0] mx_x3,
  output logic [DW-1:0] mx_x4,
  input  logic          mx_done,
  input  logic [DW-1:0] mx_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err,
  output logic          busy,
  output logic [15:0]   job_count
);

  import maxnet_pkg::*;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_out_data;
  logic              r_out_err;
  logic [15:0]       r_job_count;
  logic              w_in_hs;
  logic              w_last;
  logic              w_expire;
  logic [3:0][DW-1:0] w_slot;

  assign w_in_hs  = in_valid & in_ready;
  assign w_expire = (r_cnt == CW'(TIMEOUT - 1));

  maxnet_operand_buf #(.DW(DW)) u_buf (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (w_in_hs),
    .i_clear (busy),
    .i_wdata (in_data),
    .o_slot  (w_slot),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs depend on state only, so an async reset drops them immediately.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mx_start  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_in_hs && w_last) w_next = ST_START;
      end
      ST_START: begin
        mx_start = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (mx_done || w_expire) w_next = ST_RESULT;
      end
      ST_RESULT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_COLLECT;
      end
      default: w_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_job_count <= '0;
    end else begin
      if (r_state == ST_START) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT) && !mx_done && !w_expire) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // A done arriving on the expiry cycle takes priority over the abort.
      if (r_state == ST_WAIT) begin
        if (mx_done) begin
          r_out_data <= mx_res;
          r_out_err  <= 1'b0;
        end else if (w_expire) begin
          r_out_data <= '0;
          r_out_err  <= 1'b1;
        end
      end
      if ((r_state == ST_RESULT) && out_ready) begin
        r_job_count <= r_job_count + 16'd1;
      end
    end
  end

  assign mx_x1     = w_slot[0];
  assign mx_x2     = w_slot[1];
  assign mx_x3     = w_slot[2];
  assign mx_x4     = w_slot[3];
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign job_count = r_job_count;

endmodule

// File: tb/tb_maxnet_feeder.sv
// Self-checking bench for maxnet_feeder with a latency-programmable Maxnet stub
// and a scoreboard of expected results.
module tb_maxnet_feeder;
  import maxnet_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        mx_start;
  logic [31:0] mx_x1, mx_x2, mx_x3, mx_x4;
  logic        mx_done;
  logic [31:0] mx_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;
  logic [15:0] job_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Maxnet stub: done fires stub_lat cycles after the start cycle.
  int          since = 0;
  int          stub_lat = 3;
  bit          stub_en = 1'b0;
  logic        spurious = 1'b0;
  logic [31:0] stub_res = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [15:0] jc;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] exp_jc = 16'h0;
  logic [31:0] job_w[4];

  maxnet_feeder #(.DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mx_start(mx_start), .mx_x1(mx_x1), .mx_x2(mx_x2), .mx_x3(mx_x3), .mx_x4(mx_x4),
    .mx_done(mx_done), .mx_res(mx_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mx_start) since <= 1;
    else if (since != 0 && since < 10000) since <= since + 1;
  end

  assign mx_done = spurious | (stub_en && since == stub_lat);
  assign mx_res  = stub_res;

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    exp_jc = exp_jc + 16'd1;
    x.data = d; x.err = e; x.jc = exp_jc;
    sb.push_back(x);
  endtask

  task automatic put_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL put_word in_ready=0 required 1 after %0d cycles", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("word %08h accepted at cycle %0d", w, cyc);
  endtask

  task automatic send_job(input int gap, output int start_cyc);
    for (int i = 0; i < 4; i++) begin
      put_word(job_w[i]);
      if (i < 3) repeat (gap) @(negedge clk);
    end
    start_cyc = cyc;
    checks++;
    if (mx_start !== 1'b1) begin
      errors++; $display("FAIL start_pulse mx_start=%0b required 1", mx_start);
    end
    checks++;
    if ({mx_x1, mx_x2, mx_x3, mx_x4} !== {job_w[0], job_w[1], job_w[2], job_w[3]}) begin
      errors++;
      $display("FAIL operands x=%08h %08h %08h %08h required %08h %08h %08h %08h",
               mx_x1, mx_x2, mx_x3, mx_x4, job_w[0], job_w[1], job_w[2], job_w[3]);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL start_busy busy=%0b in_ready=%0b required 1 0", busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (mx_start !== 1'b0) begin
      errors++; $display("FAIL start_single mx_start=%0b required 0", mx_start);
    end
  endtask

  task automatic take_result(input int hold, input int exp_lat, input int start_cyc);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard empty when result awaited");
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL result_wait out_valid=%0b required 1", out_valid);
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (cyc - start_cyc != exp_lat) begin
        errors++; $display("FAIL result_latency got %0d cycles required %0d", cyc - start_cyc, exp_lat);
      end
    end
    checks++;
    if (out_data !== e.data || out_err !== e.err) begin
      errors++; $display("FAIL result_value data=%08h err=%0b required %08h %0b",
                         out_data, out_err, e.data, e.err);
    end
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0) begin
        errors++; $display("FAIL result_hold valid=%0b data=%08h in_ready=%0b required 1 %08h 0",
                           out_valid, out_data, in_ready, e.data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || job_count !== e.jc) begin
      errors++; $display("FAIL result_consume valid=%0b in_ready=%0b job_count=%04h required 0 1 %04h",
                         out_valid, in_ready, job_count, e.jc);
    end
    $display("result data=%08h err=%0b job_count=%04h", out_data, out_err, job_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || mx_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_data !== 32'h0 || out_err !== 1'b0 || job_count !== 16'h0 ||
        {mx_x1, mx_x2, mx_x3, mx_x4} !== 128'h0) begin
      errors++;
      $display("FAIL %s in_ready=%0b start=%0b valid=%0b busy=%0b data=%08h err=%0b jc=%04h x1=%08h required reset values",
               tag, in_ready, mx_start, out_valid, busy, out_data, out_err, job_count, mx_x1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_basic();
    int sc;
    job_w = '{FP_0P2, FP_0P4, FP_0P6, FP_0P8};
    stub_en = 1'b1; stub_lat = 3; stub_res = FP_0P8;
    push_exp(FP_0P8, 1'b0);
    send_job(0, sc);
    take_result(0, 4, sc);
  endtask

  task automatic test_gapped();
    int sc;
    job_w = '{FP_0P8, FP_0P6, FP_0P4, FP_0P2};
    stub_en = 1'b1; stub_lat = 3; stub_res = FP_0P6;
    push_exp(FP_0P6, 1'b0);
    send_job(2, sc);
    take_result(5, 4, sc);
  endtask

  task automatic test_timeout();
    int sc;
    job_w = '{32'h1, 32'h2, 32'h3, 32'h4};
    stub_en = 1'b0; stub_res = 32'hDEADBEEF;
    push_exp(32'h0, 1'b1);
    send_job(0, sc);
    take_result(1, TMO + 1, sc);
  endtask

  task automatic test_done_at_expiry();
    int sc;
    job_w = '{FP_0P4, FP_0P4, FP_0P2, FP_0P6};
    stub_en = 1'b1; stub_lat = TMO; stub_res = FP_0P4;
    push_exp(FP_0P4, 1'b0);
    send_job(0, sc);
    take_result(0, TMO + 1, sc);
  endtask

  task automatic test_spurious_done();
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mx_start !== 1'b0) begin
        errors++; $display("FAIL spurious_done in_ready=%0b busy=%0b valid=%0b start=%0b required 1 0 0 0",
                           in_ready, busy, out_valid, mx_start);
      end
    end
    spurious = 1'b0;
    $display("spurious done in COLLECT ignored");
  endtask

  task automatic test_reset_mid();
    int sc;
    stub_en = 1'b0;
    job_w = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
    for (int i = 0; i < 4; i++) put_word(job_w[i]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    @(negedge clk);
    rst = 1'b1;
    exp_jc = 16'h0;
    sb.delete();
    put_word(32'hBBBB0001);
    put_word(32'hBBBB0002);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_partial");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    job_w = '{32'hCCCC0001, 32'hCCCC0002, 32'hCCCC0003, 32'hCCCC0004};
    stub_en = 1'b1; stub_lat = 2; stub_res = 32'h12345678;
    push_exp(32'h12345678, 1'b0);
    send_job(1, sc);
    take_result(0, 3, sc);
  endtask

  task automatic test_wrap();
    int sc;
    @(negedge clk);
    force dut.r_job_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_job_count;
    exp_jc = 16'hFFFE;
    stub_en = 1'b1; stub_lat = 1;
    for (int j = 0; j < 2; j++) begin
      job_w = '{32'(j), 32'(j + 10), 32'(j + 20), 32'(j + 30)};
      stub_res = 32'h5A5A0000 + 32'(j);
      push_exp(stub_res, 1'b0);
      send_job(0, sc);
      take_result(0, 2, sc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_done_at_expiry();
    test_spurious_done();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
